imem_loader: RTL and testbench

Host-side program loader that feeds the miniMips core. It accepts a byte stream over a valid/ready handshake and assembles 9-bit instructions from byte pairs. It writes them into instruction memory through its write port, then drives the core's `start` and waits for the core's `done`. It is the writer for the instruction memory the core reads, and the initiator for the core's start/done pair.

---
 rtl/imem_loader_if.sv | 35 +++
 rtl/imem_loader.sv | 224 ++++++++++++++++++++++
 tb/tb_imem_loader.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: groups the host byte stream, the instruction-memory write port and the
// core start/done pair into one bundle. The master modport is the loader's view; the slave
// modport is the view of the host, memory and core around it.
interface imem_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       imem_we;
    logic [7:0] imem_addr;
    logic [8:0] imem_wdata;
    logic       core_start;
    logic       core_done;

    modport master (
        input  rx_data,
        input  rx_valid,
        input  core_done,
        output rx_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata,
        output core_start
    );

    modport slave (
        output rx_data,
        output rx_valid,
        output core_done,
        input  rx_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata,
        input  core_start
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles 9-bit instructions from a host byte stream, writes them into the
// instruction memory, then starts the core and waits for it to report done.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader #(
    parameter int unsigned START_CYCLES = 2,
    parameter logic [7:0]  BASE_ADDR    = 8'h00
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.master bus,
    output logic          busy,
    output logic          run_done,
    output logic          err,
    output logic [8:0]    word_cnt
);
    localparam int unsigned   CntW      = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [CntW-1:0] StartLast = CntW'(START_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLo,
        StHi,
        StWr,
`ifdef IMEM_LOADER_CHECKSUM_EN
        StChk,
`endif
        StStart,
        StRun
    } state_e;

    state_e          r_state, w_state_d;
    logic            r_rdy_en;
    logic [8:0]      r_count, w_count_d;
    logic [7:0]      r_lo, w_lo_d;
    logic            r_imem_we, w_imem_we_d;
    logic [7:0]      r_imem_addr, w_imem_addr_d;
    logic [8:0]      r_imem_wdata, w_imem_wdata_d;
    logic            r_core_start, w_core_start_d;
    logic [CntW-1:0] r_start_cnt, w_start_cnt_d;
    logic            r_busy, w_busy_d;
    logic            r_run_done, w_run_done_d;
    logic            r_err, w_err_d;
    logic [8:0]      r_word_cnt, w_word_cnt_d;
    logic            w_rx_ready;
    logic            w_accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]      r_csum, w_csum_d;
`endif

    // Ready decodes the byte-accepting states; r_rdy_en keeps it low while in reset
    always_comb begin
        w_rx_ready = 1'b0;
        case (r_state)
            StIdle, StLo, StHi: w_rx_ready = r_rdy_en;
`ifdef IMEM_LOADER_CHECKSUM_EN
            StChk:              w_rx_ready = r_rdy_en;
`endif
            default:            w_rx_ready = 1'b0;
        endcase
    end

    assign w_accept = bus.rx_valid && w_rx_ready;

    // Next-state and next-value logic for every registered output
    always_comb begin
        w_state_d      = r_state;
        w_count_d      = r_count;
        w_lo_d         = r_lo;
        w_imem_we_d    = 1'b0;
        w_imem_addr_d  = r_imem_addr;
        w_imem_wdata_d = r_imem_wdata;
        w_core_start_d = 1'b0;
        w_start_cnt_d  = r_start_cnt;
        w_run_done_d   = r_run_done;
        w_err_d        = r_err;
        w_word_cnt_d   = r_word_cnt;
`ifdef IMEM_LOADER_CHECKSUM_EN
        w_csum_d       = r_csum;
`endif
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    // Header 0 encodes a full 256-word image
                    w_count_d     = {(bus.rx_data == 8'd0), bus.rx_data};
                    w_run_done_d  = 1'b0;
                    w_err_d       = 1'b0;
                    w_word_cnt_d  = 9'd0;
                    w_imem_addr_d = BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_csum_d      = bus.rx_data;
`endif
                    w_state_d     = StLo;
                end
            end
            StLo: begin
                if (w_accept) begin
                    w_lo_d    = bus.rx_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_csum_d  = r_csum ^ bus.rx_data;
`endif
                    w_state_d = StHi;
                end
            end
            StHi: begin
                if (w_accept) begin
                    w_imem_wdata_d = {bus.rx_data[0], r_lo};
                    w_imem_we_d    = 1'b1;
                    if (bus.rx_data[7:1] != 7'd0) begin
                        w_err_d = 1'b1;
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_csum_d       = r_csum ^ bus.rx_data;
`endif
                    w_state_d      = StWr;
                end
            end
            StWr: begin
                w_imem_addr_d = r_imem_addr + 8'd1;
                w_word_cnt_d  = r_word_cnt + 9'd1;
                if ((r_word_cnt + 9'd1) < r_count) begin
                    w_state_d = StLo;
                end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_state_d = StChk;
`else
                    if (r_err) begin
                        w_state_d = StIdle;
                    end else begin
                        w_state_d      = StStart;
                        w_core_start_d = 1'b1;
                        w_start_cnt_d  = '0;
                    end
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            StChk: begin
                if (w_accept) begin
                    if (r_err || (bus.rx_data != r_csum)) begin
                        w_err_d   = 1'b1;
                        w_state_d = StIdle;
                    end else begin
                        w_state_d      = StStart;
                        w_core_start_d = 1'b1;
                        w_start_cnt_d  = '0;
                    end
                end
            end
`endif
            StStart: begin
                if (r_start_cnt == StartLast) begin
                    w_state_d = StRun;
                end else begin
                    w_start_cnt_d  = r_start_cnt + 1'b1;
                    w_core_start_d = 1'b1;
                end
            end
            StRun: begin
                if (bus.core_done) begin
                    w_run_done_d = 1'b1;
                    w_state_d    = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
        w_busy_d = (w_state_d != StIdle);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_en     <= 1'b0;
            r_count      <= 9'd0;
            r_lo         <= 8'd0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= BASE_ADDR;
            r_imem_wdata <= 9'd0;
            r_core_start <= 1'b0;
            r_start_cnt  <= '0;
            r_busy       <= 1'b0;
            r_run_done   <= 1'b0;
            r_err        <= 1'b0;
            r_word_cnt   <= 9'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum       <= 8'd0;
`endif
        end else begin
            r_rdy_en     <= 1'b1;
            r_count      <= w_count_d;
            r_lo         <= w_lo_d;
            r_imem_we    <= w_imem_we_d;
            r_imem_addr  <= w_imem_addr_d;
            r_imem_wdata <= w_imem_wdata_d;
            r_core_start <= w_core_start_d;
            r_start_cnt  <= w_start_cnt_d;
            r_busy       <= w_busy_d;
            r_run_done   <= w_run_done_d;
            r_err        <= w_err_d;
            r_word_cnt   <= w_word_cnt_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum       <= w_csum_d;
`endif
        end
    end

    assign bus.rx_ready   = w_rx_ready;
    assign bus.imem_we    = r_imem_we;
    assign bus.imem_addr  = r_imem_addr;
    assign bus.imem_wdata = r_imem_wdata;
    assign bus.core_start = r_core_start;
    assign busy           = r_busy;
    assign run_done       = r_run_done;
    assign err            = r_err;
    assign word_cnt       = r_word_cnt;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized frames against a frame-level reference model.
module tb_imem_loader;
    localparam int unsigned START_CYCLES = 2;
    localparam logic [7:0]  BASE_ADDR    = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       busy;
    logic       run_done;
    logic       err;
    logic [8:0] word_cnt;

    imem_loader_if bus ();

    imem_loader #(
        .START_CYCLES(START_CYCLES),
        .BASE_ADDR   (BASE_ADDR)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .busy    (busy),
        .run_done(run_done),
        .err     (err),
        .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         stalls = 0;
    int         start_total = 0;
    logic [7:0] wr_log_a[$];
    logic [8:0] wr_log_d[$];
    logic [7:0] frame[$];
    logic [7:0] exp_a[$];
    logic [8:0] exp_d[$];
    logic       exp_err;
    int         exp_n;

    // Observe the memory port and the start strobe away from the active edge
    always @(negedge clk) begin
        if (bus.imem_we) begin
            wr_log_a.push_back(bus.imem_addr);
            wr_log_d.push_back(bus.imem_wdata);
        end
        if (bus.core_start) start_total++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
        check({tag, "_imem_we"}, 32'(bus.imem_we), 32'd0);
        check({tag, "_imem_addr"}, 32'(bus.imem_addr), 32'(BASE_ADDR));
        check({tag, "_imem_wdata"}, 32'(bus.imem_wdata), 32'd0);
        check({tag, "_core_start"}, 32'(bus.core_start), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_run_done"}, 32'(run_done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_word_cnt"}, 32'(word_cnt), 32'd0);
    endtask

    // Frame-level model: what should land in memory and whether the image is rejected
    task automatic model_frame();
        logic [7:0] lo;
        logic [7:0] hi;
        exp_a.delete();
        exp_d.delete();
        exp_n   = (frame[0] == 8'd0) ? 256 : int'(frame[0]);
        exp_err = 1'b0;
        for (int i = 0; i < exp_n; i++) begin
            lo = frame[1 + 2 * i];
            hi = frame[2 + 2 * i];
            if (hi[7:1] != 7'd0) exp_err = 1'b1;
            exp_a.push_back(8'((int'(BASE_ADDR) + i) % 256));
            exp_d.push_back({hi[0], lo});
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        begin
            logic [7:0] x;
            x = 8'd0;
            for (int i = 0; i <= 2 * exp_n; i++) x = x ^ frame[i];
            if (frame[1 + 2 * exp_n] != x) exp_err = 1'b1;
        end
`endif
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    function automatic logic [7:0] frame_xor();
        logic [7:0] x;
        x = 8'd0;
        foreach (frame[i]) x = x ^ frame[i];
        return x;
    endfunction
`endif

    task automatic build_random(input int n, input bit allow_bad);
        logic [7:0] hi;
        frame.delete();
        frame.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            hi = {7'd0, 1'($urandom)};
            if (allow_bad && ($urandom_range(0, 4) == 0)) hi[7:1] = 7'($urandom_range(1, 127));
            frame.push_back(8'($urandom));
            frame.push_back(hi);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        while (!bus.rx_ready && guard < 50) begin
            stalls++;
            guard++;
            @(negedge clk);
        end
        if (guard >= 50) check("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame();
        stalls = 0;
        for (int i = 0; i < frame.size(); i++) begin
            send_byte(frame[i]);
            if (i == 0) begin
                check("hdr_clears_run_done", 32'(run_done), 32'd0);
                check("hdr_clears_err", 32'(err), 32'd0);
                check("hdr_busy", 32'(busy), 32'd1);
            end
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic finish_core(input string tag);
        check({tag, "_pre_run_done"}, 32'(run_done), 32'd0);
        bus.core_done = 1'b1;
        @(posedge clk);
        #1;
        bus.core_done = 1'b0;
        check({tag, "_run_done"}, 32'(run_done), 32'd1);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_ready"}, 32'(bus.rx_ready), 32'd1);
    endtask

    task automatic do_load(input string tag, input bit finish_run);
        int base_w;
        int base_s;
        int nw;
        int exp_stalls;
        base_w = wr_log_a.size();
        base_s = start_total;
        model_frame();
        send_frame();
`ifdef IMEM_LOADER_CHECKSUM_EN
        exp_stalls = exp_n;
`else
        exp_stalls = exp_n - 1;
`endif
        check({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
        repeat (START_CYCLES + 6) @(posedge clk);
        #1;
        nw = wr_log_a.size() - base_w;
        check({tag, "_nwrites"}, 32'(nw), 32'(exp_n));
        for (int i = 0; i < exp_n && i < nw; i++) begin
            check({tag, "_addr"}, 32'(wr_log_a[base_w + i]), 32'(exp_a[i]));
            check({tag, "_data"}, 32'(wr_log_d[base_w + i]), 32'(exp_d[i]));
        end
        check({tag, "_word_cnt"}, 32'(word_cnt), 32'(exp_n));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_start_cycles"}, 32'(start_total - base_s),
              exp_err ? 32'd0 : 32'(START_CYCLES));
        check({tag, "_busy"}, 32'(busy), exp_err ? 32'd0 : 32'd1);
        if (finish_run && !exp_err) finish_core(tag);
    endtask

    initial begin
        int base_w;
        int base_s;
        rst_n         = 1'b0;
        bus.rx_data   = 8'd0;
        bus.rx_valid  = 1'b0;
        bus.core_done = 1'b0;
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", 32'(bus.rx_ready), 32'd0);
        @(posedge clk);
        #1;
        check("ready_after_release", 32'(bus.rx_ready), 32'd1);

        // Three-word image, core completes some cycles into RUN
        frame = '{8'd3, 8'hA5, 8'h00, 8'hFF, 8'h01, 8'h64, 8'h01};
`ifdef IMEM_LOADER_CHECKSUM_EN
        frame.push_back(frame_xor());
`endif
        do_load("t1", 1'b0);
        repeat (5) @(posedge clk);
        #1;
        finish_core("t1");

        // Reserved HI bit set; core_done high outside RUN must do nothing
        bus.core_done = 1'b1;
        frame = '{8'd1, 8'h12, 8'h02};
`ifdef IMEM_LOADER_CHECKSUM_EN
        frame.push_back(frame_xor());
`endif
        do_load("t3", 1'b0);
        check("t3_done_outside_run", 32'(run_done), 32'd0);
        bus.core_done = 1'b0;

        // Full 256-word image
        build_random(256, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        frame.push_back(frame_xor());
`endif
        do_load("t4", 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        frame = '{8'd1, 8'h34, 8'h01, 8'h34};
        do_load("csum_ok", 1'b1);
        frame = '{8'd1, 8'h34, 8'h01, 8'h35};
        do_load("csum_bad", 1'b1);
`endif

        // Randomized images, some with reserved-bit or checksum errors
        for (int k = 0; k < 8; k++) begin
            build_random(int'($urandom_range(1, 6)), 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
            frame.push_back(frame_xor() ^ (($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00));
`endif
            do_load("rnd", 1'b1);
        end

        // Reset while the third write is being issued
        frame = '{8'd3, 8'h11, 8'h00, 8'h22, 8'h01, 8'h33, 8'h00};
        base_w = wr_log_a.size();
        base_s = start_total;
        for (int i = 0; i < 7; i++) send_byte(frame[i]);
        check("rst_we_pending", 32'(bus.imem_we), 32'd1);
        rst_n        = 1'b0;
        bus.rx_valid = 1'b0;
        #1;
        check_reset_values("rst_mid");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_nwrites", 32'(wr_log_a.size() - base_w), 32'd2);
        check("rst_nostart", 32'(start_total - base_s), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        build_random(3, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        frame.push_back(frame_xor());
`endif
        do_load("post_rst", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
